pipe_scroller: RTL

Consumer of the slow game tick. Each single-cycle `tick` strobe shifts a playfield of pipe columns one column left and injects a new column at the right edge. The new column is either empty or a pipe with a randomly placed gap. The block also gives the bird/collision logic the column at the bird's position, plus a one-cycle score pulse each time a pipe clears the bird.

---
 rtl/flappy_pkg.sv | 18 +
 rtl/pipe_lfsr.sv | 24 ++
 rtl/pipe_scroller.sv | 94 +++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared playfield types and the pipe-column builder used by the scroller.
package flappy_pkg;

  localparam int ROWS_DEF = 16;
  localparam int COLS_DEF = 16;

  typedef logic [ROWS_DEF-1:0] column_t;

  // Solid column with GAP open rows starting at gap_top (row 0 is the top).
  function automatic column_t make_pipe(input int gap_top, input int gap);
    column_t col;
    for (int r = 0; r < ROWS_DEF; r++) begin
      col[r] = (r < gap_top) || (r >= gap_top + gap);
    end
    return col;
  endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4), steps every clock.
// Async active-low reset seeds it to 8'h01; output is the registered state.
module pipe_lfsr (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] lfsr
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls the pipe playfield one column left per qualifying tick and spawns pipes every SPACING ticks.
// Updates land one cycle after the tick edge; no backpressure, back-to-back ticks each shift.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int GAP      = 4,
  parameter int SPACING  = 4,
  parameter int BIRD_COL = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       startGame,
  input  logic                       gameOver,
  output logic [COLS-1:0][ROWS-1:0]  pipes,
  output logic [ROWS-1:0]            birdColumn,
  output logic                       scorePulse
);

  localparam int SPC_W = (SPACING > 2) ? $clog2(SPACING) : 1;
  localparam int SLACK = ROWS - GAP;

  logic [7:0]                lfsr;
  logic [3:0]                lfsr_unused;
  logic                      adv;
  int                        gap_top;
  column_t                   pipe_full;
  logic [ROWS-1:0]           spawn_col;

  logic [COLS-1:0][ROWS-1:0] pipes_q, pipes_d;
  logic [SPC_W-1:0]          spc_q, spc_d;
  logic                      score_q, score_d;

  pipe_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign lfsr_unused = lfsr[7:4];
  assign adv         = tick & startGame & ~gameOver;

  // Gap values past the last legal top row fold back into range.
  always_comb begin
    gap_top = int'(lfsr[3:0]);
    if (gap_top > SLACK) begin
      gap_top = gap_top - SLACK;
    end
    pipe_full = make_pipe(gap_top, GAP);
  end

  assign spawn_col = pipe_full[ROWS-1:0];

  always_comb begin
    pipes_d = pipes_q;
    spc_d   = spc_q;
    score_d = 1'b0;
    if (!startGame) begin
      pipes_d = '0;
      spc_d   = '0;
    end else if (adv) begin
      score_d = |pipes_q[BIRD_COL];
      for (int c = 0; c < COLS - 1; c++) begin
        pipes_d[c] = pipes_q[c+1];
      end
      if (spc_q == SPC_W'(SPACING - 1)) begin
        pipes_d[COLS-1] = spawn_col;
        spc_d           = '0;
      end else begin
        pipes_d[COLS-1] = '0;
        spc_d           = spc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipes_q <= '0;
      spc_q   <= '0;
      score_q <= 1'b0;
    end else begin
      pipes_q <= pipes_d;
      spc_q   <= spc_d;
      score_q <= score_d;
    end
  end

  assign pipes      = pipes_q;
  assign birdColumn = pipes_q[BIRD_COL];
  assign scorePulse = score_q;

endmodule
